bt656_capture_ctrl: RTL and testbench
=====================================

Name: bt656_capture_ctrl

Overview:
Frame-capture sequencer between the BT.656 sync decoder and the pixel-to-memory DMA writer.
- Arms on a software start and locks to the next frame start from decoded SAV/EAV codes.
- Gates pixel writes to active video only and ping-pongs the DMA base address between two frame buffers.
- Checks line length and line count, and reports frame completion and errors to the register block.

Parameters:
CNT_W, 12, width of byte/line counters and of the config length fields
ADDR_W, 32, frame buffer address width
FCNT_W, 16, completed-frame counter width
TIMEOUT_CYCLES, 1048576, watchdog limit in clk cycles (used only with the optional feature)

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
cfg_start_i  in  1  one-cycle start pulse
cfg_stop_i  in  1  one-cycle stop pulse
cfg_continuous_i  in  1  1 = capture frames back to back; 0 = single frame
cfg_progressive_i  in  1  1 = frame is one field; 0 = interlaced F0+F1
cfg_buf0_addr_i  in  ADDR_W  buffer 0 base address
cfg_buf1_addr_i  in  ADDR_W  buffer 1 base address
cfg_bytes_per_line_i  in  CNT_W  expected data bytes per active line
cfg_lines_i  in  CNT_W  expected active lines per frame
sync_valid_i  in  1  one-cycle strobe: XY code decoded
sync_f_i, sync_v_i, sync_h_i  in  1 each  F/V/H bits of the decoded code (H=1 EAV, H=0 SAV)
pix_valid_i  in  1  one video data byte present; never coincident with sync_valid_i
dma_busy_i  in  1  DMA still flushing writes
cap_en_o  out  1  datapath may write the current byte
buf_addr_o  out  ADDR_W  base address of the buffer being filled
buf_sel_o  out  1  0 = buf0, 1 = buf1
busy_o  out  1  state != IDLE
frame_done_o  out  1  one-cycle pulse per completed frame
frame_cnt_o  out  FCNT_W  completed frames, wraps
line_cnt_o  out  CNT_W  active lines in current frame
err_len_o, err_lines_o, err_timeout_o  out  1 each  sticky errors

Behaviour:
- Reset values: all outputs 0; buf_addr_o = cfg_buf0_addr_i (combinational mux on buf_sel_o); state IDLE.
- States: IDLE, ARM, CAPTURE, DRAIN.
- IDLE -> ARM on cfg_start_i.
  - Clears the error flags, line_cnt, and the stop_pending flag.
  - Does not clear frame_cnt or buf_sel.
  - cfg_start_i in any other state is ignored.
- ARM:
  - Sets seen_vblank on any sync event with v=1.
  - -> CAPTURE on a SAV (h=0) with v=0, f=0 while seen_vblank=1. This line is captured.
  - cfg_stop_i -> IDLE the next cycle.
- CAPTURE:
  - line_active is set the cycle after SAV with v=0 and cleared on any EAV.
  - cap_en_o = line_active & pix_valid_i (combinational; zero added latency).
  - Byte counter increments on cap_en_o and saturates at all-ones.
  - On EAV while line_active: compare byte count to cfg_bytes_per_line_i (mismatch sets err_len), line_cnt++ (saturating), byte counter -> 0.
  - Frame end:
    - interlaced: first sync event with v=1, f=0 after at least one active f=1 line;
    - progressive: first v=1 sync event after at least one active line.
  - At frame end: compare line_cnt to cfg_lines_i (mismatch sets err_lines), then -> DRAIN.
  - cfg_stop_i sets stop_pending; the current frame completes normally.
- DRAIN:
  - Wait while dma_busy_i=1.
  - On the first cycle with dma_busy_i=0: pulse frame_done_o, frame_cnt++, toggle buf_sel_o, line_cnt -> 0.
  - Next state: ARM with seen_vblank=1 if cfg_continuous_i=1 and stop_pending=0; otherwise IDLE.
  - Frame start events arriving during DRAIN are missed. The next frame is caught in ARM.
- Simultaneous events:
  - cfg_stop_i with the frame-end event: stop takes effect and the block ends in IDLE after DRAIN.
  - cfg_start_i with cfg_stop_i in IDLE: start wins.
- Sync code parity is checked by the decoder; this block trusts F/V/H.
- rstn low mid-capture: immediate return to reset values; buffer contents are not guaranteed.

Optional Feature:
BT656_CAP_TIMEOUT_EN
- Defined:
  - In ARM and CAPTURE a counter runs and resets on every sync_valid_i.
  - Reaching TIMEOUT_CYCLES-1 sets err_timeout, forces IDLE, and produces no frame_done_o.
- Undefined: no counter; err_timeout_o tied to 0.

Test Plan:
1. Progressive stream (cfg_progressive_i=1, 4 lines x 40 bytes, cfg 40/4), single start -> one frame_done_o pulse, frame_cnt=1, buf_sel 0->1, 160 cap_en_o cycles, no errors, busy_o low afterwards.
2. Interlaced stream (4 lines/field x 40 bytes, cfg 40/8), start asserted mid-frame -> first partial frame skipped; capture begins at next F0 SAV after vblank; line_cnt reaches 8, frame_done_o pulses once.
3. Continuous mode, 3 frames, dma_busy_i held high 20 cycles after each frame end -> frame_done_o delayed exactly until dma_busy_i falls; buf_addr_o alternates buf0/buf1/buf0; frame_cnt=3.
4. One line of 38 bytes and cfg_lines_i=5 against 4 real lines -> err_len_o=1 and err_lines_o=1 (sticky); frame still completes; next cfg_start_i clears both.
5. cfg_stop_i mid-CAPTURE in continuous mode -> current frame completes, one frame_done_o pulse, then IDLE; cfg_stop_i in ARM -> IDLE next cycle with no frame_done_o.
6. (BT656_CAP_TIMEOUT_EN, TIMEOUT_CYCLES=100) sync strobes stop after SAV -> err_timeout_o=1 and IDLE exactly 100 cycles after the last sync_valid_i.

Source files
------------

// File: rtl/bt656_capture_ctrl.sv
// BT.656 frame-capture sequencer: locks to a frame start, gates pixel writes, ping-pongs DMA buffers.
// Optional sync watchdog is compiled in when BT656_CAP_TIMEOUT_EN is defined.
module bt656_capture_ctrl #(
    parameter int unsigned CNT_W          = 12,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned FCNT_W         = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cfg_start_i,
    input  logic              cfg_stop_i,
    input  logic              cfg_continuous_i,
    input  logic              cfg_progressive_i,
    input  logic [ADDR_W-1:0] cfg_buf0_addr_i,
    input  logic [ADDR_W-1:0] cfg_buf1_addr_i,
    input  logic [CNT_W-1:0]  cfg_bytes_per_line_i,
    input  logic [CNT_W-1:0]  cfg_lines_i,
    input  logic              sync_valid_i,
    input  logic              sync_f_i,
    input  logic              sync_v_i,
    input  logic              sync_h_i,
    input  logic              pix_valid_i,
    input  logic              dma_busy_i,
    output logic              cap_en_o,
    output logic [ADDR_W-1:0] buf_addr_o,
    output logic              buf_sel_o,
    output logic              busy_o,
    output logic              frame_done_o,
    output logic [FCNT_W-1:0] frame_cnt_o,
    output logic [CNT_W-1:0]  line_cnt_o,
    output logic              err_len_o,
    output logic              err_lines_o,
    output logic              err_timeout_o
);
    typedef enum logic [1:0] {StIdle, StArm, StCapture, StDrain} state_e;

    localparam logic [CNT_W-1:0]  CntOne  = CNT_W'(1);
    localparam logic [FCNT_W-1:0] FcntOne = FCNT_W'(1);

    state_e             state_q, state_d;
    logic               seen_vblank_q, seen_vblank_d;
    logic               line_active_q, line_active_d;
    logic               stop_pending_q, stop_pending_d;
    logic               got_line_q, got_line_d;
    logic               got_f1_q, got_f1_d;
    logic               buf_sel_q, buf_sel_d;
    logic               frame_done_q, frame_done_d;
    logic               err_len_q, err_len_d;
    logic               err_lines_q, err_lines_d;
    logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [CNT_W-1:0]   line_cnt_q, line_cnt_d;
    logic [FCNT_W-1:0]  frame_cnt_q, frame_cnt_d;

    logic               sav_active, eav, line_end, frame_end;
    logic [CNT_W-1:0]   line_cnt_inc;

    assign sav_active   = sync_valid_i & ~sync_h_i & ~sync_v_i;
    assign eav          = sync_valid_i & sync_h_i;
    assign line_end     = (state_q == StCapture) & eav & line_active_q;
    assign line_cnt_inc = (line_cnt_q == '1) ? line_cnt_q : line_cnt_q + CntOne;
    // Interlaced frames end on the F0 vblank that follows an F1 active line.
    assign frame_end    = (state_q == StCapture) & sync_valid_i & sync_v_i &
                          (cfg_progressive_i ? (got_line_q | line_end) : (~sync_f_i & got_f1_q));

`ifdef BT656_CAP_TIMEOUT_EN
    localparam int unsigned TmoW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
    logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic            err_timeout_q, err_timeout_d;
`endif

    always_comb begin
        state_d        = state_q;
        seen_vblank_d  = seen_vblank_q;
        line_active_d  = line_active_q;
        stop_pending_d = stop_pending_q;
        got_line_d     = got_line_q;
        got_f1_d       = got_f1_q;
        buf_sel_d      = buf_sel_q;
        frame_done_d   = 1'b0;
        err_len_d      = err_len_q;
        err_lines_d    = err_lines_q;
        byte_cnt_d     = byte_cnt_q;
        line_cnt_d     = line_cnt_q;
        frame_cnt_d    = frame_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (cfg_start_i) begin
                    state_d        = StArm;
                    err_len_d      = 1'b0;
                    err_lines_d    = 1'b0;
                    line_cnt_d     = '0;
                    stop_pending_d = 1'b0;
                    seen_vblank_d  = 1'b0;
                end
            end
            StArm: begin
                if (cfg_stop_i) begin
                    state_d = StIdle;
                end else if (sav_active && !sync_f_i && seen_vblank_q) begin
                    state_d       = StCapture;
                    line_active_d = 1'b1;
                    byte_cnt_d    = '0;
                    got_line_d    = 1'b0;
                    got_f1_d      = 1'b0;
                end else if (sync_valid_i && sync_v_i) begin
                    seen_vblank_d = 1'b1;
                end
            end
            StCapture: begin
                if (cfg_stop_i) stop_pending_d = 1'b1;
                if (cap_en_o && byte_cnt_q != '1) byte_cnt_d = byte_cnt_q + CntOne;
                if (sav_active) line_active_d = 1'b1;
                if (eav) line_active_d = 1'b0;
                if (line_end) begin
                    if (byte_cnt_q != cfg_bytes_per_line_i) err_len_d = 1'b1;
                    line_cnt_d = line_cnt_inc;
                    byte_cnt_d = '0;
                    got_line_d = 1'b1;
                    if (sync_f_i) got_f1_d = 1'b1;
                end
                if (frame_end) begin
                    if (line_cnt_d != cfg_lines_i) err_lines_d = 1'b1;
                    line_active_d = 1'b0;
                    state_d       = StDrain;
                end
            end
            StDrain: begin
                if (cfg_stop_i) stop_pending_d = 1'b1;
                if (!dma_busy_i) begin
                    frame_done_d = 1'b1;
                    frame_cnt_d  = frame_cnt_q + FcntOne;
                    buf_sel_d    = ~buf_sel_q;
                    line_cnt_d   = '0;
                    if (cfg_continuous_i && !stop_pending_q && !cfg_stop_i) begin
                        state_d       = StArm;
                        seen_vblank_d = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
`ifdef BT656_CAP_TIMEOUT_EN
        tmo_cnt_d     = '0;
        err_timeout_d = err_timeout_q;
        if (state_q == StIdle && cfg_start_i) err_timeout_d = 1'b0;
        if ((state_q == StArm || state_q == StCapture) && !sync_valid_i) begin
            if (tmo_cnt_q == TmoLast) begin
                err_timeout_d = 1'b1;
                line_active_d = 1'b0;
                state_d       = StIdle;
            end else begin
                tmo_cnt_d = tmo_cnt_q + TmoW'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q        <= StIdle;
            seen_vblank_q  <= 1'b0;
            line_active_q  <= 1'b0;
            stop_pending_q <= 1'b0;
            got_line_q     <= 1'b0;
            got_f1_q       <= 1'b0;
            buf_sel_q      <= 1'b0;
            frame_done_q   <= 1'b0;
            err_len_q      <= 1'b0;
            err_lines_q    <= 1'b0;
            byte_cnt_q     <= '0;
            line_cnt_q     <= '0;
            frame_cnt_q    <= '0;
        end else begin
            state_q        <= state_d;
            seen_vblank_q  <= seen_vblank_d;
            line_active_q  <= line_active_d;
            stop_pending_q <= stop_pending_d;
            got_line_q     <= got_line_d;
            got_f1_q       <= got_f1_d;
            buf_sel_q      <= buf_sel_d;
            frame_done_q   <= frame_done_d;
            err_len_q      <= err_len_d;
            err_lines_q    <= err_lines_d;
            byte_cnt_q     <= byte_cnt_d;
            line_cnt_q     <= line_cnt_d;
            frame_cnt_q    <= frame_cnt_d;
        end
    end

`ifdef BT656_CAP_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            tmo_cnt_q     <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q     <= tmo_cnt_d;
            err_timeout_q <= err_timeout_d;
        end
    end
    assign err_timeout_o = err_timeout_q;
`else
    assign err_timeout_o = 1'b0;
`endif

    assign cap_en_o     = line_active_q & pix_valid_i;
    assign buf_sel_o    = buf_sel_q;
    assign buf_addr_o   = buf_sel_q ? cfg_buf1_addr_i : cfg_buf0_addr_i;
    assign busy_o       = (state_q != StIdle);
    assign frame_done_o = frame_done_q;
    assign frame_cnt_o  = frame_cnt_q;
    assign line_cnt_o   = line_cnt_q;
    assign err_len_o    = err_len_q;
    assign err_lines_o  = err_lines_q;

endmodule

// File: tb/tb_bt656_capture_ctrl.sv
// Directed + randomized bench for bt656_capture_ctrl; expectations come from per-frame byte/line tallies.
module tb_bt656_capture_ctrl;
    localparam int unsigned CNT_W  = 12;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned FCNT_W = 16;
`ifdef BT656_CAP_TIMEOUT_EN
    localparam int unsigned TMO = 100;
`else
    localparam int unsigned TMO = 1048576;
`endif
    localparam logic [ADDR_W-1:0] Buf0 = 32'h1000_0000;
    localparam logic [ADDR_W-1:0] Buf1 = 32'h2000_4000;

    logic clk = 1'b0;
    logic rstn;
    logic cfg_start_i, cfg_stop_i, cfg_continuous_i, cfg_progressive_i;
    logic [CNT_W-1:0] cfg_bytes_per_line_i, cfg_lines_i;
    logic sync_valid_i, sync_f_i, sync_v_i, sync_h_i, pix_valid_i, dma_busy_i;
    logic cap_en_o, buf_sel_o, busy_o, frame_done_o;
    logic [ADDR_W-1:0] buf_addr_o;
    logic [FCNT_W-1:0] frame_cnt_o;
    logic [CNT_W-1:0]  line_cnt_o;
    logic err_len_o, err_lines_o, err_timeout_o;

    bt656_capture_ctrl #(
        .CNT_W(CNT_W), .ADDR_W(ADDR_W), .FCNT_W(FCNT_W), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rstn(rstn),
        .cfg_start_i(cfg_start_i), .cfg_stop_i(cfg_stop_i),
        .cfg_continuous_i(cfg_continuous_i), .cfg_progressive_i(cfg_progressive_i),
        .cfg_buf0_addr_i(Buf0), .cfg_buf1_addr_i(Buf1),
        .cfg_bytes_per_line_i(cfg_bytes_per_line_i), .cfg_lines_i(cfg_lines_i),
        .sync_valid_i(sync_valid_i), .sync_f_i(sync_f_i), .sync_v_i(sync_v_i),
        .sync_h_i(sync_h_i), .pix_valid_i(pix_valid_i), .dma_busy_i(dma_busy_i),
        .cap_en_o(cap_en_o), .buf_addr_o(buf_addr_o), .buf_sel_o(buf_sel_o),
        .busy_o(busy_o), .frame_done_o(frame_done_o), .frame_cnt_o(frame_cnt_o),
        .line_cnt_o(line_cnt_o), .err_len_o(err_len_o), .err_lines_o(err_lines_o),
        .err_timeout_o(err_timeout_o)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int cap_seen = 0, done_seen = 0;
    int exp_frames = 0;
    int lens[$];

    always @(negedge clk) begin
        if (rstn) begin
            if (cap_en_o) cap_seen++;
            if (frame_done_o) done_seen++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sync(input logic f, input logic v, input logic h);
        sync_valid_i = 1'b1; sync_f_i = f; sync_v_i = v; sync_h_i = h;
        cyc();
        sync_valid_i = 1'b0;
    endtask

    task automatic line(input logic f, input logic v, input int n);
        sync(f, v, 1'b0);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) cyc();
            pix_valid_i = 1'b1;
            cyc();
            pix_valid_i = 1'b0;
        end
        sync(f, v, 1'b1);
        cyc();
        cyc();
    endtask

    task automatic pulse_start();
        cfg_start_i = 1'b1; cyc(); cfg_start_i = 1'b0;
    endtask

    task automatic pulse_stop();
        cfg_stop_i = 1'b1; cyc(); cfg_stop_i = 1'b0;
    endtask

    task automatic field_active(input logic f, input int start_after);
        for (int i = 0; i < lens.size(); i++) begin
            if (i == start_after) pulse_start();
            line(f, 1'b0, lens[i]);
        end
    endtask

    // Two vblank lines then active lines; interlaced adds the F1 field.
    task automatic send_frame(input logic prog, input int start_after);
        line(1'b0, 1'b1, 3);
        line(1'b0, 1'b1, 3);
        field_active(1'b0, start_after);
        if (!prog) begin
            line(1'b1, 1'b1, 3);
            line(1'b1, 1'b1, 3);
            field_active(1'b1, -1);
        end
    endtask

    task automatic end_frame();
        line(1'b0, 1'b1, 3);
    endtask

    task automatic end_frame_busy(input int n);
        int d;
        dma_busy_i = 1'b1;
        sync(1'b0, 1'b1, 1'b0);
        d = done_seen;
        repeat (n) cyc();
        chk("drain_hold", 64'(done_seen - d), 64'd0);
        chk("drain_hold_pulse", {63'd0, frame_done_o}, 64'd0);
        dma_busy_i = 1'b0;
        cyc();
        chk("done_on_release", {63'd0, frame_done_o}, 64'd1);
        for (int i = 0; i < 3; i++) begin
            pix_valid_i = 1'b1; cyc(); pix_valid_i = 1'b0;
        end
        sync(1'b0, 1'b1, 1'b1);
        cyc();
    endtask

    function automatic int sum_lens();
        int s = 0;
        foreach (lens[i]) s += lens[i];
        return s;
    endfunction

    task automatic chk_frame_regs(input string tag);
        chk({tag, "_frame_cnt"}, 64'(frame_cnt_o), 64'(exp_frames % 65536));
        chk({tag, "_buf_sel"}, {63'd0, buf_sel_o}, 64'(exp_frames % 2));
        chk({tag, "_buf_addr"}, 64'(buf_addr_o), 64'((exp_frames % 2) ? Buf1 : Buf0));
    endtask

    initial begin
        int c0, d0, bpl, nl_cfg, nl, e_len, e_lines;
        rstn = 1'b0;
        cfg_start_i = 0; cfg_stop_i = 0; cfg_continuous_i = 0; cfg_progressive_i = 1;
        cfg_bytes_per_line_i = 12'd40; cfg_lines_i = 12'd4;
        sync_valid_i = 0; sync_f_i = 0; sync_v_i = 0; sync_h_i = 0;
        pix_valid_i = 0; dma_busy_i = 0;
        repeat (3) cyc();
        rstn = 1'b1;
        cyc();

        chk("rst_busy", {63'd0, busy_o}, 64'd0);
        chk("rst_cap_en", {63'd0, cap_en_o}, 64'd0);
        chk("rst_done", {63'd0, frame_done_o}, 64'd0);
        chk("rst_line_cnt", 64'(line_cnt_o), 64'd0);
        chk("rst_errs", {61'd0, err_len_o, err_lines_o, err_timeout_o}, 64'd0);
        chk_frame_regs("rst");

        // Progressive single frame, 4x40
        lens = '{40, 40, 40, 40};
        c0 = cap_seen; d0 = done_seen;
        pulse_start();
        chk("t1_busy_arm", {63'd0, busy_o}, 64'd1);
        send_frame(1'b1, -1);
        chk("t1_line_cnt", 64'(line_cnt_o), 64'd4);
        end_frame();
        exp_frames++;
        chk("t1_done", 64'(done_seen - d0), 64'd1);
        chk("t1_cap", 64'(cap_seen - c0), 64'd160);
        chk("t1_errs", {62'd0, err_len_o, err_lines_o}, 64'd0);
        chk("t1_busy", {63'd0, busy_o}, 64'd0);
        chk_frame_regs("t1");

        // Interlaced, start mid-frame: partial frame skipped
        cfg_progressive_i = 0; cfg_lines_i = 12'd8;
        c0 = cap_seen; d0 = done_seen;
        send_frame(1'b0, 2);
        chk("t2_skip", 64'(cap_seen - c0), 64'd0);
        send_frame(1'b0, -1);
        chk("t2_line_cnt", 64'(line_cnt_o), 64'd8);
        end_frame();
        exp_frames++;
        chk("t2_done", 64'(done_seen - d0), 64'd1);
        chk("t2_cap", 64'(cap_seen - c0), 64'(2 * sum_lens()));
        chk("t2_errs", {62'd0, err_len_o, err_lines_o}, 64'd0);
        chk_frame_regs("t2");

        // Continuous, 3 frames, DMA busy 20 cycles after each frame end
        cfg_progressive_i = 1; cfg_lines_i = 12'd4; cfg_continuous_i = 1;
        c0 = cap_seen;
        pulse_start();
        for (int k = 0; k < 3; k++) begin
            send_frame(1'b1, -1);
            chk("t3_addr", 64'(buf_addr_o), 64'((exp_frames % 2) ? Buf1 : Buf0));
            end_frame_busy(20);
            exp_frames++;
            chk("t3_busy_rearm", {63'd0, busy_o}, 64'd1);
        end
        pulse_stop();
        cfg_continuous_i = 0;
        chk("t3_cap", 64'(cap_seen - c0), 64'd480);
        chk("t3_busy", {63'd0, busy_o}, 64'd0);
        chk_frame_regs("t3");

        // Short line and wrong line count
        cfg_lines_i = 12'd5;
        lens = '{40, 38, 40, 40};
        d0 = done_seen;
        pulse_start();
        send_frame(1'b1, -1);
        end_frame();
        exp_frames++;
        repeat (5) cyc();
        chk("t4_err_len", {63'd0, err_len_o}, 64'd1);
        chk("t4_err_lines", {63'd0, err_lines_o}, 64'd1);
        chk("t4_done", 64'(done_seen - d0), 64'd1);
        chk_frame_regs("t4");
        pulse_start();
        chk("t4_clear", {62'd0, err_len_o, err_lines_o}, 64'd0);
        pulse_stop();
        chk("t4_stop_arm", {63'd0, busy_o}, 64'd0);

        // Stop mid-capture in continuous mode
        cfg_lines_i = 12'd4; cfg_continuous_i = 1;
        lens = '{40, 40, 40, 40};
        c0 = cap_seen; d0 = done_seen;
        pulse_start();
        line(1'b0, 1'b1, 3);
        line(1'b0, 1'b1, 3);
        line(1'b0, 1'b0, 40);
        line(1'b0, 1'b0, 40);
        pulse_stop();
        line(1'b0, 1'b0, 40);
        line(1'b0, 1'b0, 40);
        end_frame();
        exp_frames++;
        send_frame(1'b1, -1);
        end_frame();
        chk("t5_done", 64'(done_seen - d0), 64'd1);
        chk("t5_cap", 64'(cap_seen - c0), 64'd160);
        chk("t5_busy", {63'd0, busy_o}, 64'd0);
        chk_frame_regs("t5");
        c0 = cap_seen; d0 = done_seen;
        pulse_start();
        pulse_stop();
        chk("t5_arm_stop", {63'd0, busy_o}, 64'd0);
        send_frame(1'b1, -1);
        end_frame();
        chk("t5_arm_done", 64'(done_seen - d0), 64'd0);
        chk("t5_arm_cap", 64'(cap_seen - c0), 64'd0);
        cfg_continuous_i = 0;

        // Randomized progressive frames against a per-frame tally
        for (int it = 0; it < 4; it++) begin
            bpl = $urandom_range(6, 20);
            nl_cfg = $urandom_range(2, 4);
            nl = nl_cfg + (($urandom_range(0, 2) == 0) ? 1 : 0);
            lens = {};
            e_len = 0;
            for (int i = 0; i < nl; i++) begin
                int l;
                l = bpl + (($urandom_range(0, 5) == 0) ? 1 : 0) - (($urandom_range(0, 5) == 0) ? 2 : 0);
                lens.push_back(l);
                if (l != bpl) e_len = 1;
            end
            e_lines = (nl != nl_cfg) ? 1 : 0;
            cfg_bytes_per_line_i = CNT_W'(bpl);
            cfg_lines_i = CNT_W'(nl_cfg);
            c0 = cap_seen; d0 = done_seen;
            pulse_start();
            send_frame(1'b1, -1);
            chk("t7_line_cnt", 64'(line_cnt_o), 64'(nl));
            end_frame();
            exp_frames++;
            chk("t7_err_len", {63'd0, err_len_o}, 64'(e_len));
            chk("t7_err_lines", {63'd0, err_lines_o}, 64'(e_lines));
            chk("t7_cap", 64'(cap_seen - c0), 64'(sum_lens()));
            chk("t7_done", 64'(done_seen - d0), 64'd1);
            chk_frame_regs("t7");
        end

`ifdef BT656_CAP_TIMEOUT_EN
        // Sync strobes stop right after an active SAV
        d0 = done_seen;
        pulse_start();
        line(1'b0, 1'b1, 3);
        sync(1'b0, 1'b0, 1'b0);
        repeat (99) cyc();
        chk("t6_busy_99", {63'd0, busy_o}, 64'd1);
        chk("t6_tmo_99", {63'd0, err_timeout_o}, 64'd0);
        cyc();
        chk("t6_busy_100", {63'd0, busy_o}, 64'd0);
        chk("t6_tmo_100", {63'd0, err_timeout_o}, 64'd1);
        chk("t6_done", 64'(done_seen - d0), 64'd0);
        pulse_start();
        chk("t6_tmo_clear", {63'd0, err_timeout_o}, 64'd0);
        pulse_stop();
`else
        chk("tmo_tied", {63'd0, err_timeout_o}, 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
